// File: rtl/b32to128_ctrl.sv
// Sequencer for the 32-to-128-bit packer: counts accepted host words, drives the
// packer enable/index and holds the completed block on a valid/ready handshake.
module b32to128_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             pk_enable,
    output logic [1:0]       pk_nr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       wcnt,
    output logic             busy,
    output logic [CNT_W-1:0] blk_count
);

    logic [1:0]       wcnt_q, wcnt_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] blk_count_q, blk_count_d;
    logic             accept;
    logic             consume;

    // The 4th word would overwrite dataOut, so it waits for the pending block to
    // leave; out_ready is deliberately kept out of this term.
    assign in_ready  = !flush && !((wcnt_q == 2'd3) && out_valid_q);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid_q && out_ready;

    assign pk_enable = accept;
    assign pk_nr     = wcnt_q;
    assign wcnt      = wcnt_q;
    assign out_valid = out_valid_q;
    assign blk_count = blk_count_q;
    assign busy      = (wcnt_q != 2'd0) || out_valid_q;

    always_comb begin
        wcnt_d      = wcnt_q;
        out_valid_d = out_valid_q;
        blk_count_d = blk_count_q;
        if (flush) begin
            wcnt_d      = 2'd0;
            out_valid_d = 1'b0;
        end else begin
            if (accept) begin
                wcnt_d = wcnt_q + 2'd1;
            end
            // Completion and consumption cannot coincide: the 4th word is only
            // accepted while out_valid is low.
            if (accept && (wcnt_q == 2'd3)) begin
                out_valid_d = 1'b1;
            end else if (consume) begin
                out_valid_d = 1'b0;
            end
            if (consume) begin
                blk_count_d = blk_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wcnt_q      <= 2'd0;
            out_valid_q <= 1'b0;
            blk_count_q <= '0;
        end else begin
            wcnt_q      <= wcnt_d;
            out_valid_q <= out_valid_d;
            blk_count_q <= blk_count_d;
        end
    end

endmodule

// File: tb/tb_b32to128_ctrl.sv
// Directed and randomised bench for b32to128_ctrl with a behavioural packer
// attached to pk_enable/pk_nr so block contents can be checked.
module tb_b32to128_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] din = '0;
    logic        in_ready, pk_enable, out_valid, busy;
    logic [1:0]  pk_nr, wcnt;
    logic [15:0] blk_count;

    logic        in_valid2 = 1'b0;
    logic        out_ready2 = 1'b0;
    logic        in_ready2, pk_enable2, out_valid2, busy2;
    logic [1:0]  pk_nr2, wcnt2;
    logic [1:0]  blk_count2;

    logic [31:0]  tmp [4];
    logic [127:0] pk_out = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    b32to128_ctrl #(.CNT_W(16)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pk_enable(pk_enable), .pk_nr(pk_nr),
        .out_valid(out_valid), .out_ready(out_ready),
        .wcnt(wcnt), .busy(busy), .blk_count(blk_count)
    );

    b32to128_ctrl #(.CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .flush(1'b0),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .pk_enable(pk_enable2), .pk_nr(pk_nr2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .wcnt(wcnt2), .busy(busy2), .blk_count(blk_count2)
    );

    // Behavioural packer: tmp words by index, dataOut loaded with the 4th word.
    always @(posedge clock) begin
        if (pk_enable) begin
            tmp[pk_nr] <= din;
            if (pk_nr == 2'd3) pk_out <= {tmp[0], tmp[1], tmp[2], din};
        end
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Four back-to-back words base+0..3 with no stall expected.
    task automatic send4(input logic [31:0] base, input logic rdy);
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            din       = base + i;
            out_ready = rdy;
            #1;
            check_val("send_nr", pk_nr, i);
            check_val("send_en", pk_enable, 1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    function automatic logic [127:0] blk(input logic [31:0] base);
        return {base, base + 32'd1, base + 32'd2, base + 32'd3};
    endfunction

    logic [31:0] wr [1000];
    logic [1:0]  exp_cnt2 [5];
    logic        ir_a, ir_b;
    int k, nb, cyc;

    initial begin
        exp_cnt2[0] = 2'd1; exp_cnt2[1] = 2'd2; exp_cnt2[2] = 2'd3;
        exp_cnt2[3] = 2'd0; exp_cnt2[4] = 2'd1;

        // Reset values
        #1;
        check_val("rst_wcnt", wcnt, 0);
        check_val("rst_ov", out_valid, 0);
        check_val("rst_cnt", blk_count, 0);
        check_val("rst_ir", in_ready, 1);
        check_val("rst_en", pk_enable, 0);
        check_val("rst_nr", pk_nr, 0);
        check_val("rst_busy", busy, 0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // 1: one block, downstream ready
        send4(32'hA000_0000, 1'b1);
        #1;
        check_val("t1_ov", out_valid, 1);
        check_val("t1_blk", pk_out, blk(32'hA000_0000));
        check_val("t1_cnt0", blk_count, 0);
        tick();
        #1;
        check_val("t1_ov_clr", out_valid, 0);
        check_val("t1_cnt1", blk_count, 1);
        tick();

        // 2: pending block with backpressure, next block stalls on its 4th word
        send4(32'hC100_0000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            din = 32'hB000_0000 + ((i < 3) ? i : 3);
            tick();
        end
        #1;
        check_val("t2_wcnt", wcnt, 3);
        check_val("t2_ir", in_ready, 0);
        check_val("t2_ov", out_valid, 1);
        check_val("t2_hold", pk_out, blk(32'hC100_0000));
        out_ready = 1'b1;
        #1;
        check_val("t2_ir_or", in_ready, 0);
        tick();
        out_ready = 1'b0;
        #1;
        check_val("t2_ov_gone", out_valid, 0);
        check_val("t2_ir_back", in_ready, 1);
        check_val("t2_nr3", pk_nr, 3);
        check_val("t2_cnt", blk_count, 2);
        tick();
        in_valid = 1'b0;
        #1;
        check_val("t2_ov2", out_valid, 1);
        check_val("t2_blk", pk_out, blk(32'hB000_0000));
        out_ready = 1'b1;
        tick();
        #1;
        check_val("t2_cnt2", blk_count, 3);

        // 3: flush discards a partial block
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; din = 32'hEE00_0000 + i;
            tick();
        end
        flush = 1'b1;
        #1;
        check_val("t3_ir_fl", in_ready, 0);
        check_val("t3_en_fl", pk_enable, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check_val("t3_wcnt", wcnt, 0);
        send4(32'hC000_0000, 1'b1);
        #1;
        check_val("t3_blk", pk_out, blk(32'hC000_0000));
        tick();
        #1;
        check_val("t3_cnt", blk_count, 4);

        // 4: flush drops a pending block, then async reset mid-block
        send4(32'hD000_0000, 1'b0);
        #1;
        check_val("t4_ov", out_valid, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check_val("t4_ov_fl", out_valid, 0);
        check_val("t4_cnt", blk_count, 4);
        check_val("t4_busy", busy, 0);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; din = 32'hE000_0000 + i;
            tick();
        end
        in_valid = 1'b0;
        #1;
        check_val("t4_wcnt2", wcnt, 2);
        reset = 1'b0;
        #1;
        check_val("t4_r_wcnt", wcnt, 0);
        check_val("t4_r_nr", pk_nr, 0);
        check_val("t4_r_busy", busy, 0);
        check_val("t4_r_cnt", blk_count, 0);
        check_val("t4_r_ir", in_ready, 1);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // 5: counter wrap on the 2-bit instance
        out_ready2 = 1'b1;
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 4; i++) begin
                in_valid2 = 1'b1;
                tick();
            end
            in_valid2 = 1'b0;
            tick();
            #1;
            check_val("t5_cnt", blk_count2, exp_cnt2[b]);
        end

        // 6: random handshakes, scoreboard on block contents and order
        for (int i = 0; i < 1000; i++) wr[i] = $urandom;
        k = 0; nb = 0; cyc = 0;
        while ((k < 1000 || out_valid) && cyc < 20000) begin
            in_valid  = (k < 1000) && $urandom_range(0, 1);
            din       = (k < 1000) ? wr[k] : 32'h0;
            out_ready = $urandom_range(0, 1);
            #1;
            ir_a = in_ready;
            out_ready = !out_ready;
            #1;
            ir_b = in_ready;
            out_ready = !out_ready;
            #1;
            check_val("t6_ir_indep", ir_b, ir_a);
            check_val("t6_en", pk_enable, in_valid && in_ready);
            if (out_valid && out_ready) begin
                check_val("t6_blk", pk_out, {wr[4*nb], wr[4*nb+1], wr[4*nb+2], wr[4*nb+3]});
                nb++;
            end
            if (in_valid && in_ready) k++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        check_val("t6_words", k, 1000);
        check_val("t6_blocks", nb, 250);
        check_val("t6_cnt", blk_count, 250);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
